// File: rtl/tlb_translate_if.sv
// Request, cache-stage, page-table-walker and bypass signals of the TLB translate stage.
interface tlb_translate_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int PAGE_BITS  = 8,
  parameter int REG_BITS   = 3
);
  localparam int PN_W = ADDR_WIDTH - PAGE_BITS;

  logic                  enable_tlblookup;
  logic                  block_previous;
  logic [ADDR_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [1:0]            ldst_enable;
  logic                  word_access_in;
  logic [REG_BITS-1:0]   dest_reg_in;
  logic                  we_in;
  logic [1:0]            bp_in;

  logic [ADDR_WIDTH-1:0] paddr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            ldst_out;
  logic                  we_out;
  logic [1:0]            bp_out;
  logic [REG_BITS-1:0]   dest_reg_out;
  logic                  word_access_out;
  logic                  tlb_fault_out;

  logic                  ptw_req;
  logic [PN_W-1:0]       ptw_vpn;
  logic                  ptw_ready;
  logic [PN_W-1:0]       ptw_ppn;
  logic                  ptw_fault;

  logic [REG_BITS-1:0]   dest_reg_cache;
  logic [DATA_WIDTH-1:0] cache_result;
  logic [1:0]            bp_cache;
  logic [REG_BITS-1:0]   dest_reg_wb;
  logic [DATA_WIDTH-1:0] wb_result;
  logic [1:0]            bp_wb;

  modport slave (
    input  enable_tlblookup, alu_result, data_reg, ldst_enable, word_access_in,
           dest_reg_in, we_in, bp_in, ptw_ready, ptw_ppn, ptw_fault,
           dest_reg_cache, cache_result, bp_cache, dest_reg_wb, wb_result, bp_wb,
    output block_previous, paddr_out, data_out, ldst_out, we_out, bp_out,
           dest_reg_out, word_access_out, tlb_fault_out, ptw_req, ptw_vpn
  );

  modport master (
    output enable_tlblookup, alu_result, data_reg, ldst_enable, word_access_in,
           dest_reg_in, we_in, bp_in, ptw_ready, ptw_ppn, ptw_fault,
           dest_reg_cache, cache_result, bp_cache, dest_reg_wb, wb_result, bp_wb,
    input  block_previous, paddr_out, data_out, ldst_out, we_out, bp_out,
           dest_reg_out, word_access_out, tlb_fault_out, ptw_req, ptw_vpn
  );
endinterface

// File: rtl/tlb_translate_stage.sv
// Memory-pipeline stage: registers the ALU request, translates it through a fully
// associative TLB with PTW refill, and bypasses store data. TLB_FLUSH_EN adds tlb_flush.
module tlb_translate_stage #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int PAGE_BITS   = 8,
  parameter int NUM_ENTRIES = 4,
  parameter int REG_BITS    = 3
) (
  input  logic clk,
  input  logic reset,
`ifdef TLB_FLUSH_EN
  input  logic tlb_flush,
`endif
  tlb_translate_if.slave bus
);
  localparam int PN_W  = ADDR_WIDTH - PAGE_BITS;
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {IDLE, WALK, FAULT} state_t;

  logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            ldst_q, ldst_d;
  logic                  word_q, word_d;
  logic [REG_BITS-1:0]   dest_q, dest_d;
  logic                  we_q, we_d;
  logic [1:0]            bp_q, bp_d;

  logic [NUM_ENTRIES-1:0]           valid_q, valid_d;
  logic [NUM_ENTRIES-1:0][PN_W-1:0] vpn_q, vpn_d;
  logic [NUM_ENTRIES-1:0][PN_W-1:0] ppn_q, ppn_d;
  logic [IDX_W-1:0]                 victim_q, victim_d;
  state_t                           state_q, state_d;
  logic                             flushed_q, flushed_d;

  logic             flush;
  logic [PN_W-1:0]  vpn;
  logic             hit, miss, mem_access, block, load_en;
  logic [IDX_W-1:0] hit_idx;

`ifdef TLB_FLUSH_EN
  assign flush = tlb_flush;
`else
  assign flush = 1'b0;
`endif

  assign vpn = vaddr_q[ADDR_WIDTH-1:PAGE_BITS];

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!hit && valid_q[i] && vpn_q[i] == vpn) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign mem_access = |ldst_q;
  assign miss       = mem_access && !hit;
  assign block      = (miss && state_q != FAULT) || state_q == WALK;
  assign load_en    = bus.enable_tlblookup && !block;

  // Pipeline register holds its request while stalled or disabled.
  always_comb begin
    vaddr_d = vaddr_q;
    data_d  = data_q;
    ldst_d  = ldst_q;
    word_d  = word_q;
    dest_d  = dest_q;
    we_d    = we_q;
    bp_d    = bp_q;
    if (load_en) begin
      vaddr_d = bus.alu_result;
      data_d  = bus.data_reg;
      ldst_d  = bus.ldst_enable;
      word_d  = bus.word_access_in;
      dest_d  = bus.dest_reg_in;
      we_d    = bus.we_in;
      bp_d    = bus.bp_in;
    end
  end

  // flushed_q remembers a flush seen mid-walk so that walk's result is dropped.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    vpn_d     = vpn_q;
    ppn_d     = ppn_q;
    victim_d  = victim_q;
    flushed_d = flushed_q;
    case (state_q)
      IDLE: begin
        flushed_d = 1'b0;
        if (miss) state_d = WALK;
      end
      WALK: begin
        if (flush) flushed_d = 1'b1;
        if (bus.ptw_ready) begin
          flushed_d = 1'b0;
          if (flush || flushed_q) begin
            state_d = IDLE;
          end else if (bus.ptw_fault) begin
            state_d = FAULT;
          end else begin
            state_d           = IDLE;
            valid_d[victim_q] = 1'b1;
            vpn_d[victim_q]   = vpn;
            ppn_d[victim_q]   = bus.ptw_ppn;
            victim_d          = victim_q + IDX_W'(1);
          end
        end
      end
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      valid_d  = '0;
      victim_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vaddr_q   <= '0;
      data_q    <= '0;
      ldst_q    <= '0;
      word_q    <= 1'b0;
      dest_q    <= '0;
      we_q      <= 1'b0;
      bp_q      <= '0;
      valid_q   <= '0;
      vpn_q     <= '0;
      ppn_q     <= '0;
      victim_q  <= '0;
      state_q   <= IDLE;
      flushed_q <= 1'b0;
    end else begin
      vaddr_q   <= vaddr_d;
      data_q    <= data_d;
      ldst_q    <= ldst_d;
      word_q    <= word_d;
      dest_q    <= dest_d;
      we_q      <= we_d;
      bp_q      <= bp_d;
      valid_q   <= valid_d;
      vpn_q     <= vpn_d;
      ppn_q     <= ppn_d;
      victim_q  <= victim_d;
      state_q   <= state_d;
      flushed_q <= flushed_d;
    end
  end

  assign bus.block_previous  = block;
  assign bus.ldst_out        = (block || state_q == FAULT) ? 2'b00 : ldst_q;
  assign bus.we_out          = (block || state_q == FAULT) ? 1'b0 : we_q;
  assign bus.bp_out          = block ? 2'b00 : bp_q;
  assign bus.dest_reg_out    = dest_q;
  assign bus.word_access_out = word_q;
  assign bus.tlb_fault_out   = state_q == FAULT;
  assign bus.ptw_req         = state_q == WALK;
  assign bus.ptw_vpn         = (state_q == WALK) ? vpn : '0;
  assign bus.paddr_out       = hit ? {ppn_q[hit_idx], vaddr_q[PAGE_BITS-1:0]} : vaddr_q;

  // Only an outgoing store takes bypassed data; CACHE wins over WB.
  always_comb begin
    bus.data_out = data_q;
    if (bus.ldst_out == 2'b01) begin
      if (dest_q == bus.dest_reg_cache && bus.bp_cache == 2'd2)
        bus.data_out = bus.cache_result;
      else if (dest_q == bus.dest_reg_wb && bus.bp_wb == 2'd2)
        bus.data_out = bus.wb_result;
    end
  end
endmodule

// File: tb/tb_tlb_translate_stage.sv
// Directed bench for tlb_translate_stage: miss/refill, hit, replacement, fault, bypass, reset-in-walk.
module tb_tlb_translate_stage;
  logic clk = 1'b0;
  logic reset;
`ifdef TLB_FLUSH_EN
  logic tlb_flush = 1'b0;
`endif
  int checks   = 0;
  int failures = 0;

  tlb_translate_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .PAGE_BITS(8), .REG_BITS(3)) bus ();

  tlb_translate_stage #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .PAGE_BITS(8), .NUM_ENTRIES(4), .REG_BITS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef TLB_FLUSH_EN
    .tlb_flush(tlb_flush),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] ldst,
                         input logic [2:0] dest, input logic we, input logic [1:0] bp);
    bus.enable_tlblookup = 1'b1;
    bus.alu_result       = addr;
    bus.data_reg         = data;
    bus.ldst_enable      = ldst;
    bus.dest_reg_in      = dest;
    bus.we_in            = we;
    bus.bp_in            = bp;
    bus.word_access_in   = 1'b1;
  endtask

  task automatic do_fill(input logic [7:0] vpn, input logic [7:0] ppn);
    set_req({vpn, 8'h10}, 16'h0, 2'b10, 3'd1, 1'b1, 2'd0);
    tick();
    chk("fill_miss_block", bus.block_previous, 1);
    set_req(16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 2'd0);
    tick();
    chk("fill_ptw_req", bus.ptw_req, 1);
    chk("fill_ptw_vpn", bus.ptw_vpn, vpn);
    bus.ptw_ready = 1'b1;
    bus.ptw_ppn   = ppn;
    tick();
    bus.ptw_ready = 1'b0;
    chk("fill_paddr", bus.paddr_out, {ppn, 8'h10});
  endtask

  initial begin
    reset = 1'b1;
    set_req(16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 2'd0);
    bus.enable_tlblookup = 1'b0;
    bus.ptw_ready = 1'b0; bus.ptw_ppn = '0; bus.ptw_fault = 1'b0;
    bus.dest_reg_cache = '0; bus.cache_result = '0; bus.bp_cache = '0;
    bus.dest_reg_wb = '0; bus.wb_result = '0; bus.bp_wb = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ldst", bus.ldst_out, 0);
    chk("rst_block", bus.block_previous, 0);
    chk("rst_ptw_req", bus.ptw_req, 0);
    chk("rst_paddr", bus.paddr_out, 0);
    chk("rst_fault", bus.tlb_fault_out, 0);
    chk("rst_data", bus.data_out, 0);

    // Store to 0x1234 misses, walks, then completes with PPN 0x56
    set_req(16'h1234, 16'hBEEF, 2'b01, 3'd3, 1'b0, 2'd0);
    tick();
    set_req(16'h12A0, 16'h1111, 2'b10, 3'd5, 1'b1, 2'd2);
    chk("t1_block", bus.block_previous, 1);
    chk("t1_bubble_ldst", bus.ldst_out, 0);
    chk("t1_bubble_we", bus.we_out, 0);
    tick();
    chk("t1_ptw_req", bus.ptw_req, 1);
    chk("t1_ptw_vpn", bus.ptw_vpn, 16'h12);
    chk("t1_walk_block", bus.block_previous, 1);
    bus.ptw_ready = 1'b1; bus.ptw_ppn = 8'h56;
    tick();
    bus.ptw_ready = 1'b0;
    chk("t1_paddr", bus.paddr_out, 16'h5634);
    chk("t1_ldst", bus.ldst_out, 2'b01);
    chk("t1_unblock", bus.block_previous, 0);
    chk("t1_data", bus.data_out, 16'hBEEF);
    chk("t1_ptw_req_low", bus.ptw_req, 0);

    // Load 0x12A0 hits with no stall
    tick();
    chk("t2_paddr", bus.paddr_out, 16'h56A0);
    chk("t2_ldst", bus.ldst_out, 2'b10);
    chk("t2_block", bus.block_previous, 0);
    chk("t2_we", bus.we_out, 1);
    chk("t2_bp", bus.bp_out, 2);
    chk("t2_dest", bus.dest_reg_out, 5);

    // Store-data bypass priority
    set_req(16'h1200, 16'h0AAA, 2'b01, 3'd3, 1'b0, 2'd0);
    bus.dest_reg_cache = 3'd3; bus.cache_result = 16'hC0DE; bus.bp_cache = 2'd2;
    bus.dest_reg_wb    = 3'd3; bus.wb_result    = 16'hB0B0; bus.bp_wb    = 2'd2;
    tick();
    chk("t5_cache_pri", bus.data_out, 16'hC0DE);
    bus.bp_cache = 2'd1;
    #1;
    chk("t5_wb", bus.data_out, 16'hB0B0);
    bus.bp_wb = 2'd1;
    #1;
    chk("t5_nobypass", bus.data_out, 16'h0AAA);
    bus.bp_cache = 2'd2; bus.bp_wb = 2'd2;
    set_req(16'h1200, 16'h0BBB, 2'b10, 3'd3, 1'b1, 2'd0);
    tick();
    chk("t5_load_ldst", bus.ldst_out, 2'b10);
    chk("t5_load_data", bus.data_out, 16'h0BBB);
    bus.bp_cache = 2'd0; bus.bp_wb = 2'd0;

    // Walk fault on VPN 0x7F: one-cycle fault, then advance
    set_req(16'h7F20, 16'h0, 2'b10, 3'd2, 1'b1, 2'd0);
    tick();
    set_req(16'h3344, 16'h0, 2'b00, 3'd4, 1'b1, 2'd0);
    chk("t4_block", bus.block_previous, 1);
    tick();
    chk("t4_ptw_vpn", bus.ptw_vpn, 16'h7F);
    bus.ptw_ready = 1'b1; bus.ptw_fault = 1'b1;
    tick();
    bus.ptw_ready = 1'b0; bus.ptw_fault = 1'b0;
    chk("t4_fault", bus.tlb_fault_out, 1);
    chk("t4_fault_ldst", bus.ldst_out, 0);
    chk("t4_fault_we", bus.we_out, 0);
    chk("t4_fault_block", bus.block_previous, 0);
    tick();
    chk("t4_fault_gone", bus.tlb_fault_out, 0);
    chk("t4_adv_paddr", bus.paddr_out, 16'h3344);
    chk("t4_adv_we", bus.we_out, 1);
    chk("t4_adv_block", bus.block_previous, 0);

    // Replacement: five fills into four entries from a clean TLB
    set_req(16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 2'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t3_rst_ldst", bus.ldst_out, 0);
    for (int v = 1; v <= 5; v++) do_fill(8'(v), 8'(8'hA0 + v));
    set_req(16'h0433, 16'h0, 2'b10, 3'd1, 1'b1, 2'd0);
    tick();
    chk("t3_hit04_block", bus.block_previous, 0);
    chk("t3_hit04_paddr", bus.paddr_out, 16'hA433);
    set_req(16'h0155, 16'h0, 2'b10, 3'd1, 1'b1, 2'd0);
    tick();
    chk("t3_evicted01_miss", bus.block_previous, 1);

    // Reset mid-walk, then a late ptw_ready must be ignored
    set_req(16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 2'd0);
    tick();
    chk("t6_walk", bus.ptw_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_req", bus.ptw_req, 0);
    chk("t6_rst_block", bus.block_previous, 0);
    set_req(16'h0155, 16'h0, 2'b10, 3'd1, 1'b1, 2'd0);
    bus.ptw_ready = 1'b1; bus.ptw_ppn = 8'h99;
    tick();
    bus.ptw_ready = 1'b0;
    set_req(16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 2'd0);
    chk("t6_idle_req", bus.ptw_req, 0);
    chk("t6_nowrite_miss", bus.block_previous, 1);
    tick();
    chk("t6_rewalk_vpn", bus.ptw_vpn, 16'h01);
    bus.ptw_ready = 1'b1; bus.ptw_ppn = 8'h77;
    tick();
    bus.ptw_ready = 1'b0;
    chk("t6_refill_paddr", bus.paddr_out, 16'h7755);

`ifdef TLB_FLUSH_EN
    tlb_flush = 1'b1;
    tick();
    tlb_flush = 1'b0;
    set_req(16'h0155, 16'h0, 2'b10, 3'd1, 1'b1, 2'd0);
    tick();
    chk("flush_miss", bus.block_previous, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
